// File: rtl/drive_arbiter_if.sv
// Handshake bundle between the requesters, the shared sink and drive_arbiter.
// req_last exists only when DRIVE_ARBITER_LOCK_EN is defined.
interface drive_arbiter_if #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 8
);
    logic [NREQ-1:0]       req;
    logic [NREQ*WIDTH-1:0] data;
    logic [NREQ-1:0]       gnt;
    logic                  out_valid;
    logic [WIDTH-1:0]      out_data;
    logic                  out_ready;
    logic                  idle;
`ifdef DRIVE_ARBITER_LOCK_EN
    logic [NREQ-1:0]       req_last;
`endif

    // master: requesters plus sink; slave: the arbiter itself
    modport master (
        output req, data, out_ready,
`ifdef DRIVE_ARBITER_LOCK_EN
        output req_last,
`endif
        input  gnt, out_valid, out_data, idle
    );

    modport slave (
        input  req, data, out_ready,
`ifdef DRIVE_ARBITER_LOCK_EN
        input  req_last,
`endif
        output gnt, out_valid, out_data, idle
    );
endinterface

// File: rtl/drive_arbiter.sv
// Round-robin arbiter sharing one registered output driver among NREQ requesters.
// Define DRIVE_ARBITER_LOCK_EN to add multi-beat grant locking via req_last.
module drive_arbiter #(
    parameter int NREQ    = 4,
    parameter int WIDTH   = 8,
    parameter int DEFAULT = 9
) (
    input  logic            clk,
    input  logic            rst_n,
    drive_arbiter_if.slave  bus
);
    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

`ifdef DRIVE_ARBITER_LOCK_EN
    typedef enum logic [1:0] {IDLE, GRANT, LOCK} state_t;
`else
    typedef enum logic [1:0] {IDLE, GRANT} state_t;
`endif

    state_t                     state;
    logic [PW-1:0]              ptr, win_q, win, ptr_next;
    logic                       found;
    logic [NREQ-1:0]            gnt_q;
    logic                       out_valid_q;
    logic [WIDTH-1:0]           out_data_q;
    logic [NREQ-1:0][WIDTH-1:0] slices;

    assign slices = bus.data;

    // First requester at or after ptr, wrapping modulo NREQ
    always_comb begin
        found = 1'b0;
        win   = '0;
        for (int i = 0; i < NREQ; i++) begin
            int idx;
            idx = (int'(ptr) + i) % NREQ;
            if (!found && bus.req[idx]) begin
                found = 1'b1;
                win   = PW'(idx);
            end
        end
    end

    assign ptr_next = (win_q == PW'(NREQ - 1)) ? '0 : win_q + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            gnt_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= WIDTH'(DEFAULT);
            ptr         <= '0;
            win_q       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (found) begin
                        state       <= GRANT;
                        win_q       <= win;
                        gnt_q       <= NREQ'(1) << win;
                        out_valid_q <= 1'b1;
                        out_data_q  <= slices[win];
                    end
                end
                GRANT: begin
                    // accept takes priority over a same-cycle withdrawal
                    if (out_valid_q && bus.out_ready) begin
`ifdef DRIVE_ARBITER_LOCK_EN
                        if (!bus.req_last[win_q]) begin
                            state       <= LOCK;
                            out_valid_q <= 1'b0;
                        end else begin
                            state       <= IDLE;
                            gnt_q       <= '0;
                            out_valid_q <= 1'b0;
                            ptr         <= ptr_next;
                        end
`else
                        state       <= IDLE;
                        gnt_q       <= '0;
                        out_valid_q <= 1'b0;
                        ptr         <= ptr_next;
`endif
                    end else if (!bus.req[win_q]) begin
                        state       <= IDLE;
                        gnt_q       <= '0;
                        out_valid_q <= 1'b0;
                    end
                end
`ifdef DRIVE_ARBITER_LOCK_EN
                LOCK: begin
                    if (!bus.req[win_q]) begin
                        state <= IDLE;
                        gnt_q <= '0;
                    end else begin
                        state       <= GRANT;
                        out_valid_q <= 1'b1;
                        out_data_q  <= slices[win_q];
                    end
                end
`endif
                default: begin
                    state       <= IDLE;
                    gnt_q       <= '0;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.gnt       = gnt_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.idle      = (state == IDLE);
endmodule

// File: tb/tb_drive_arbiter.sv
// Scoreboard bench for drive_arbiter (NREQ=4, WIDTH=8, DEFAULT=9); the lock scenario
// runs only when DRIVE_ARBITER_LOCK_EN is defined.
module tb_drive_arbiter;
    logic clk = 1'b0;
    logic rst_n;
    int   vectors = 0;
    int   miscompares = 0;

    typedef struct {
        logic [3:0] gnt;
        logic [7:0] d;
    } exp_t;
    exp_t sb[$];

    drive_arbiter_if #(.NREQ(4), .WIDTH(8)) bus();

    drive_arbiter #(.NREQ(4), .WIDTH(8), .DEFAULT(9)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (bus.out_valid === 1'b1) begin
                ok = 1'b1;
                return;
            end
            cyc();
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.req = '0;
        bus.data = '0;
        bus.out_ready = 1'b0;
`ifdef DRIVE_ARBITER_LOCK_EN
        bus.req_last = '1;
`endif
        cyc(); cyc();
        vectors++;
        if (bus.out_data !== 8'd9 || bus.out_valid !== 1'b0 || bus.gnt !== 4'b0 || bus.idle !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_state: data=%h valid=%b gnt=%b idle=%b want 09/0/0000/1",
                     bus.out_data, bus.out_valid, bus.gnt, bus.idle);
        end
        rst_n = 1'b1;
        repeat (3) cyc();
        vectors++;
        if (bus.out_data !== 8'd9 || bus.out_valid !== 1'b0 || bus.gnt !== 4'b0 || bus.idle !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_no_req: data=%h valid=%b gnt=%b idle=%b want 09/0/0000/1",
                     bus.out_data, bus.out_valid, bus.gnt, bus.idle);
        end
    endtask

    task automatic test_round_robin();
        bit ok;
        exp_t e;
        bus.data = '0;
        bus.data[15:8] = 8'h11;
        bus.data[23:16] = 8'h22;
        sb.push_back('{4'b0010, 8'h11});
        sb.push_back('{4'b0100, 8'h22});
        bus.out_ready = 1'b1;
        bus.req = 4'b0110;
        cyc();
        vectors++;
        if (bus.out_valid !== 1'b1 || bus.idle !== 1'b0) begin
            miscompares++;
            $display("FAIL rr_latency: valid=%b idle=%b want 1/0", bus.out_valid, bus.idle);
        end
        for (int k = 0; k < 2; k++) begin
            wait_valid(ok);
            vectors++;
            if (!ok) begin
                miscompares++;
                $display("FAIL rr_timeout: out_valid never rose, beat %0d", k);
            end
            e = sb.pop_front();
            vectors++;
            if (bus.gnt !== e.gnt || bus.out_data !== e.d) begin
                miscompares++;
                $display("FAIL rr_grant: gnt=%b data=%h want %b/%h", bus.gnt, bus.out_data, e.gnt, e.d);
            end
            cyc();
            bus.req = bus.req & ~e.gnt;
            vectors++;
            if (bus.idle !== 1'b1 || bus.out_valid !== 1'b0 || bus.gnt !== 4'b0) begin
                miscompares++;
                $display("FAIL rr_release: idle=%b valid=%b gnt=%b want 1/0/0000",
                         bus.idle, bus.out_valid, bus.gnt);
            end
        end
    endtask

    task automatic test_wrap();
        bit ok;
        exp_t e;
        bus.data[31:24] = 8'h33;
        bus.data[7:0] = 8'h44;
        sb.push_back('{4'b1000, 8'h33});
        sb.push_back('{4'b0001, 8'h44});
        bus.req = 4'b1000;
        for (int k = 0; k < 2; k++) begin
            wait_valid(ok);
            vectors++;
            if (!ok) begin
                miscompares++;
                $display("FAIL wrap_timeout: out_valid never rose, beat %0d", k);
            end
            e = sb.pop_front();
            vectors++;
            if (bus.gnt !== e.gnt || bus.out_data !== e.d) begin
                miscompares++;
                $display("FAIL wrap_grant: gnt=%b data=%h want %b/%h", bus.gnt, bus.out_data, e.gnt, e.d);
            end
            cyc();
            // after the first accept both ends request; wrapped ptr must favour 0
            bus.req = (k == 0) ? 4'b1001 : 4'b0000;
        end
    endtask

    task automatic test_hold_withdraw();
        bit ok;
        exp_t e;
        bus.out_ready = 1'b0;
        bus.data[23:16] = 8'h55;
        sb.push_back('{4'b0100, 8'h55});
        bus.req = 4'b0100;
        wait_valid(ok);
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL hold_timeout: out_valid never rose");
        end
        e = sb.pop_front();
        vectors++;
        if (bus.gnt !== e.gnt || bus.out_data !== e.d) begin
            miscompares++;
            $display("FAIL hold_grant: gnt=%b data=%h want %b/%h", bus.gnt, bus.out_data, e.gnt, e.d);
        end
        bus.data[23:16] = 8'h66;
        repeat (3) cyc();
        vectors++;
        if (bus.out_data !== 8'h55 || bus.out_valid !== 1'b1 || bus.gnt !== 4'b0100) begin
            miscompares++;
            $display("FAIL hold_stable: data=%h valid=%b gnt=%b want 55/1/0100",
                     bus.out_data, bus.out_valid, bus.gnt);
        end
        bus.req = 4'b0000;
        cyc();
        vectors++;
        if (bus.idle !== 1'b1 || bus.gnt !== 4'b0 || bus.out_valid !== 1'b0 || bus.out_data !== 8'h55) begin
            miscompares++;
            $display("FAIL withdraw: idle=%b gnt=%b valid=%b data=%h want 1/0000/0/55",
                     bus.idle, bus.gnt, bus.out_valid, bus.out_data);
        end
        // ptr stayed at 1, so requester 1 beats requester 0
        bus.data[7:0] = 8'h0a;
        bus.data[15:8] = 8'h0b;
        sb.push_back('{4'b0010, 8'h0b});
        bus.out_ready = 1'b1;
        bus.req = 4'b0011;
        wait_valid(ok);
        e = sb.pop_front();
        vectors++;
        if (!ok || bus.gnt !== e.gnt || bus.out_data !== e.d) begin
            miscompares++;
            $display("FAIL withdraw_ptr: ok=%b gnt=%b data=%h want %b/%h", ok, bus.gnt, bus.out_data, e.gnt, e.d);
        end
        cyc();
        bus.req = 4'b0000;
        cyc();
    endtask

    task automatic test_async_reset();
        bit ok;
        exp_t e;
        bus.out_ready = 1'b0;
        bus.data[7:0] = 8'h77;
        sb.push_back('{4'b0001, 8'h77});
        bus.req = 4'b0001;
        wait_valid(ok);
        e = sb.pop_front();
        vectors++;
        if (!ok || bus.gnt !== e.gnt || bus.out_data !== e.d) begin
            miscompares++;
            $display("FAIL areset_grant: ok=%b gnt=%b data=%h want %b/%h", ok, bus.gnt, bus.out_data, e.gnt, e.d);
        end
        #2 rst_n = 1'b0;
        #1;
        vectors++;
        if (bus.out_valid !== 1'b0 || bus.gnt !== 4'b0 || bus.out_data !== 8'd9 || bus.idle !== 1'b1) begin
            miscompares++;
            $display("FAIL areset: valid=%b gnt=%b data=%h idle=%b want 0/0000/09/1",
                     bus.out_valid, bus.gnt, bus.out_data, bus.idle);
        end
        bus.req = 4'b0000;
        cyc();
        rst_n = 1'b1;
        cyc();
    endtask

`ifdef DRIVE_ARBITER_LOCK_EN
    task automatic test_lock();
        bit ok;
        exp_t e;
        bus.out_ready = 1'b1;
        bus.req_last = 4'b0000;
        bus.data[15:8] = 8'ha1;
        bus.data[7:0] = 8'hb0;
        sb.push_back('{4'b0010, 8'ha1});
        sb.push_back('{4'b0010, 8'ha2});
        sb.push_back('{4'b0010, 8'ha3});
        sb.push_back('{4'b0001, 8'hb0});
        bus.req = 4'b0010;
        for (int k = 0; k < 4; k++) begin
            wait_valid(ok);
            e = sb.pop_front();
            vectors++;
            if (!ok || bus.gnt !== e.gnt || bus.out_data !== e.d) begin
                miscompares++;
                $display("FAIL lock_beat%0d: ok=%b gnt=%b data=%h want %b/%h",
                         k, ok, bus.gnt, bus.out_data, e.gnt, e.d);
            end
            bus.req = bus.req | 4'b0001;
            cyc();
            if (k < 2) begin
                vectors++;
                if (bus.out_valid !== 1'b0 || bus.gnt !== 4'b0010 || bus.idle !== 1'b0) begin
                    miscompares++;
                    $display("FAIL lock_gap%0d: valid=%b gnt=%b idle=%b want 0/0010/0",
                             k, bus.out_valid, bus.gnt, bus.idle);
                end
                bus.data[15:8] = (k == 0) ? 8'ha2 : 8'ha3;
                if (k == 1) bus.req_last = 4'b1111;
            end else if (k == 2) begin
                bus.req = 4'b0001;
            end else begin
                bus.req = 4'b0000;
            end
        end
        cyc();
    endtask
`endif

    initial begin
        test_reset();
        test_round_robin();
        test_wrap();
        test_hold_withdraw();
        test_async_reset();
`ifdef DRIVE_ARBITER_LOCK_EN
        test_lock();
`endif
        vectors++;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard_drain: %0d entries left, want 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
